corr_result_reader: RTL and testbench



---
 rtl/corr_result_reader.sv | 172 +++++++++++++++++
 tb/tb_corr_result_reader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/corr_result_reader.sv
// Register-bus master for the correlator channel: polls CorrelationSeen, reads one
// correlation result and queues it in a first-word-fall-through result FIFO.
module corr_result_reader #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          POLL_GAP   = 8,
    parameter logic [31:0] BASE       = 32'hFE000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          bus_gnt,
    output logic [31:0]                   addr,
    output logic                          read,
    output logic                          write,
    input  logic [31:0]                   Rdata,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [31:0]                   res_cnt,
    output logic [63:0]                   res_corr,
    output logic                          res_status,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   drop_count,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(POLL_GAP) + 1;
    localparam int RW = 97;

    typedef enum logic [2:0] {
        S_IDLE, S_POLL, S_GAP, S_RD_CNT, S_RD_LOW, S_RD_HIGH, S_RD_STAT, S_PUSH
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [31:0]     cnt_q, cnt_d, low_q, low_d, high_q, high_d;
    logic            stat_q, stat_d;
    logic [RW-1:0]   mem_q [FIFO_DEPTH];
    logic [RW-1:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     drop_q, drop_d;
    logic            ovf_q, ovf_d;
    logic            push_req, push_ok, pop, full, drop;
    logic [RW-1:0]   head;

    // Sequencer: every read state stalls with the bus idle until granted.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        low_d   = low_q;
        high_d  = high_q;
        stat_d  = stat_q;
        addr    = 32'h0;
        read    = 1'b0;
        case (state_q)
            S_IDLE: if (enable) state_d = S_POLL;
            S_POLL: if (bus_gnt) begin
                addr = BASE + 32'h108;
                read = 1'b1;
                if (Rdata[0]) begin
                    state_d = S_RD_CNT;
                end else begin
                    state_d = S_GAP;
                    gap_d   = GW'(POLL_GAP - 1);
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = enable ? S_POLL : S_IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            S_RD_CNT: if (bus_gnt) begin
                addr    = BASE + 32'h600;
                read    = 1'b1;
                cnt_d   = Rdata;
                state_d = S_RD_LOW;
            end
            S_RD_LOW: if (bus_gnt) begin
                addr    = BASE + 32'h604;
                read    = 1'b1;
                low_d   = Rdata;
                state_d = S_RD_HIGH;
            end
            S_RD_HIGH: if (bus_gnt) begin
                addr    = BASE + 32'h608;
                read    = 1'b1;
                high_d  = Rdata;
                state_d = S_RD_STAT;
            end
            S_RD_STAT: if (bus_gnt) begin
                addr    = BASE + 32'h60C;
                read    = 1'b1;
                stat_d  = Rdata[0];
                state_d = S_PUSH;
            end
            S_PUSH: begin
                state_d = S_GAP;
                gap_d   = GW'(POLL_GAP - 1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        full     = (count_q == CW'(FIFO_DEPTH));
        pop      = (count_q != '0) && res_ready;
        push_req = (state_q == S_PUSH);
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        mem_d    = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = {cnt_q, high_q, low_q, stat_q};
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (overflow_clr) begin
            ovf_d  = 1'b0;
            drop_d = 16'h0;
        end else if (drop) begin
            ovf_d  = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'h1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gap_q    <= '0;
            cnt_q    <= '0;
            low_q    <= '0;
            high_q   <= '0;
            stat_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
            low_q    <= low_d;
            high_q   <= high_d;
            stat_q   <= stat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign write      = 1'b0;
    assign res_valid  = (count_q != '0);
    assign res_cnt    = head[96:65];
    assign res_corr   = head[64:1];
    assign res_status = head[0];
    assign fifo_count = count_q;
    assign drop_count = drop_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_GAP);

endmodule

// File: tb/tb_corr_result_reader.sv
// Directed bench for corr_result_reader: the bench plays the correlator bus slave
// cycle by cycle and checks addresses, captured records and FIFO bookkeeping.
module tb_corr_result_reader;

    localparam logic [31:0] A_POLL = 32'hFE000108;
    localparam logic [31:0] A_CNT  = 32'hFE000600;
    localparam logic [31:0] A_LOW  = 32'hFE000604;
    localparam logic [31:0] A_HIGH = 32'hFE000608;
    localparam logic [31:0] A_STAT = 32'hFE00060C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        bus_gnt = 1'b0;
    logic [31:0] addr;
    logic        read;
    logic        write;
    logic [31:0] Rdata = 32'h0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_cnt;
    logic [63:0] res_corr;
    logic        res_status;
    logic [2:0]  fifo_count;
    logic [15:0] drop_count;
    logic        overflow;
    logic        overflow_clr = 1'b0;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    corr_result_reader dut (
        .clk(clk), .rst(rst), .enable(enable), .bus_gnt(bus_gnt),
        .addr(addr), .read(read), .write(write), .Rdata(Rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_cnt(res_cnt),
        .res_corr(res_corr), .res_status(res_status), .fifo_count(fifo_count),
        .drop_count(drop_count), .overflow(overflow), .overflow_clr(overflow_clr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs applied on the falling edge, bus outputs checked just after.
    task automatic cyc(input logic g, input logic [31:0] rd, input logic rdy,
                       input logic [31:0] ea, input logic er, input string tag);
        @(negedge clk);
        bus_gnt   = g;
        Rdata     = rd;
        res_ready = rdy;
        #1;
        chk({tag, ".addr"}, 64'(addr), 64'(ea));
        chk({tag, ".read"}, 64'(read), 64'(er));
    endtask

    task automatic do_record(input logic [31:0] c, input logic [31:0] l, input logic [31:0] h,
                             input logic s, input logic rdy_push);
        cyc(1'b1, 32'h1, 1'b0, A_POLL, 1'b1, "rec.poll");
        cyc(1'b1, c, 1'b0, A_CNT, 1'b1, "rec.cnt");
        cyc(1'b1, l, 1'b0, A_LOW, 1'b1, "rec.low");
        cyc(1'b1, h, 1'b0, A_HIGH, 1'b1, "rec.high");
        cyc(1'b1, 32'hA5A5A5A4 | 32'(s), 1'b0, A_STAT, 1'b1, "rec.stat");
        cyc(1'b1, 32'h0, rdy_push, 32'h0, 1'b0, "rec.push");
        for (int k = 0; k < 8; k++) cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, "rec.gap");
    endtask

    task automatic chk_head(input string tag, input logic [31:0] c, input logic [63:0] corr,
                            input logic s);
        chk({tag, ".valid"}, 64'(res_valid), 64'(1));
        chk({tag, ".cnt"}, 64'(res_cnt), 64'(c));
        chk({tag, ".corr"}, res_corr, corr);
        chk({tag, ".status"}, 64'(res_status), 64'(s));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst.addr", 64'(addr), 64'(0));
        chk("rst.read", 64'(read), 64'(0));
        chk("rst.write", 64'(write), 64'(0));
        chk("rst.valid", 64'(res_valid), 64'(0));
        chk("rst.count", 64'(fifo_count), 64'(0));
        chk("rst.drop", 64'(drop_count), 64'(0));
        chk("rst.ovf", 64'(overflow), 64'(0));
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.corr", res_corr, 64'(0));
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        bus_gnt = 1'b1;

        // Poll with nothing seen: one read, eight idle cycles, then poll again
        cyc(1'b1, 32'h0, 1'b0, A_POLL, 1'b1, "t1.poll0");
        chk("t1.busy_poll", 64'(busy), 64'(1));
        for (int k = 0; k < 8; k++) cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, "t1.gap");
        chk("t1.busy_gap", 64'(busy), 64'(0));
        cyc(1'b1, 32'h0, 1'b0, A_POLL, 1'b1, "t1.poll1");
        chk("t1.count", 64'(fifo_count), 64'(0));
        for (int k = 0; k < 8; k++) cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, "t1.gap2");

        // Full record with grant held high
        cyc(1'b1, 32'h1, 1'b0, A_POLL, 1'b1, "t2.poll");
        cyc(1'b1, 32'h00001234, 1'b0, A_CNT, 1'b1, "t2.cnt");
        cyc(1'b1, 32'hFFFFFF00, 1'b0, A_LOW, 1'b1, "t2.low");
        cyc(1'b1, 32'hFFFFFFFF, 1'b0, A_HIGH, 1'b1, "t2.high");
        cyc(1'b1, 32'h00000001, 1'b0, A_STAT, 1'b1, "t2.stat");
        cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, "t2.push");
        chk("t2.valid_push", 64'(res_valid), 64'(0));
        chk("t2.busy_push", 64'(busy), 64'(1));
        cyc(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, "t2.gap1");
        chk_head("t2.head", 32'h1234, 64'hFFFFFFFF_FFFFFF00, 1'b1);
        chk("t2.count", 64'(fifo_count), 64'(1));
        for (int k = 0; k < 7; k++) cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, "t2.gap");
        chk("t2.count_popped", 64'(fifo_count), 64'(0));

        // Same record with the grant toggling; non-granted cycles carry junk data
        cyc(1'b1, 32'h1, 1'b0, A_POLL, 1'b1, "t3.poll");
        cyc(1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, "t3.cnt_wait");
        cyc(1'b1, 32'h00001234, 1'b0, A_CNT, 1'b1, "t3.cnt");
        cyc(1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, "t3.low_wait");
        cyc(1'b1, 32'hFFFFFF00, 1'b0, A_LOW, 1'b1, "t3.low");
        cyc(1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, "t3.high_wait");
        cyc(1'b1, 32'hFFFFFFFF, 1'b0, A_HIGH, 1'b1, "t3.high");
        cyc(1'b0, 32'hDEADBEEE, 1'b0, 32'h0, 1'b0, "t3.stat_wait");
        cyc(1'b1, 32'h00000001, 1'b0, A_STAT, 1'b1, "t3.stat");
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "t3.push");
        chk("t3.valid_push", 64'(res_valid), 64'(0));
        cyc(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, "t3.gap1");
        chk_head("t3.head", 32'h1234, 64'hFFFFFFFF_FFFFFF00, 1'b1);
        for (int k = 0; k < 7; k++) cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, "t3.gap");

        // Five records into a four-deep FIFO with no consumer
        for (int i = 0; i < 5; i++)
            do_record(32'h100 + i, 32'h80000000 + i, 32'(i), i[0], 1'b0);
        enable = 1'b0;
        chk("t4.count", 64'(fifo_count), 64'(4));
        chk("t4.ovf", 64'(overflow), 64'(1));
        chk("t4.drop", 64'(drop_count), 64'(1));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 32'h0, 1'b0, "t4.drain");
            chk_head("t4.head", 32'h100 + i, {32'(i), 32'h80000000 + 32'(i)}, i[0]);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "t4.empty");
        chk("t4.valid_empty", 64'(res_valid), 64'(0));
        chk("t4.count_empty", 64'(fifo_count), 64'(0));
        chk("t4.ovf_held", 64'(overflow), 64'(1));
        overflow_clr = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "t4.clr");
        overflow_clr = 1'b0;
        chk("t4.ovf_clr", 64'(overflow), 64'(0));
        chk("t4.drop_clr", 64'(drop_count), 64'(0));

        // Full FIFO with a pop in the push cycle: no drop, new record goes last
        enable = 1'b1;
        for (int j = 0; j < 5; j++)
            do_record(32'h200 + j, 32'h1000 + j, 32'hFFFFFFF0 + j, ~j[0], j == 4);
        enable = 1'b0;
        chk("t5.count", 64'(fifo_count), 64'(4));
        chk("t5.ovf", 64'(overflow), 64'(0));
        chk("t5.drop", 64'(drop_count), 64'(0));
        for (int j = 1; j < 4; j++) begin
            cyc(1'b0, 32'h0, 1'b1, 32'h0, 1'b0, "t5.drain");
            chk_head("t5.head", 32'h200 + j, {32'hFFFFFFF0 + 32'(j), 32'h1000 + 32'(j)}, ~j[0]);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "t5.last");
        chk_head("t5.tail", 32'h204, 64'hFFFFFFF4_00001004, 1'b1);
        chk("t5.count_last", 64'(fifo_count), 64'(1));

        // Reset in the middle of a record flushes the FIFO and drops the bus at once
        enable = 1'b1;
        cyc(1'b1, 32'h1, 1'b0, A_POLL, 1'b1, "t6.poll");
        cyc(1'b1, 32'h55, 1'b0, A_CNT, 1'b1, "t6.cnt");
        cyc(1'b1, 32'h66, 1'b0, A_LOW, 1'b1, "t6.low");
        #2;
        rst = 1'b1;
        #1;
        chk("t6.read", 64'(read), 64'(0));
        chk("t6.addr", 64'(addr), 64'(0));
        chk("t6.valid", 64'(res_valid), 64'(0));
        chk("t6.count", 64'(fifo_count), 64'(0));
        chk("t6.busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 32'h0, 1'b0, A_POLL, 1'b1, "t6.repoll");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
